// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller for the dual-slot VLIW pipeline: load-use interlock,
// data-memory wait with timeout, branch/jump flushes and sticky undefined-instruction halt.
module hazard_control_unit #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [2:0]       id_alu_rm,
    input  logic [2:0]       id_alu_rn,
    input  logic             id_alu_useRn,
    input  logic [2:0]       id_mem_rn,
    input  logic [2:0]       id_mem_rd,
    input  logic             id_mem_isStore,
    input  logic             ex_memRead,
    input  logic [2:0]       ex_mem_rd,
    input  logic             ex_branchTaken,
    input  logic             ex_isJump,
    input  logic             ex_alu_undefinedInstruction,
    input  logic             ex_mem_undefinedInstruction,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             p1_pipeline_regWrite,
    output logic             p2_pipeline_regWrite,
    output logic             p3_pipeline_regWrite,
    output logic             p1_flush,
    output logic             p2_flush,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {StRun, StMemWait, StHalt} state_e;

    localparam logic [1:0] CauseNone    = 2'd0;
    localparam logic [1:0] CauseAluUndef = 2'd1;
    localparam logic [1:0] CauseMemUndef = 2'd2;
    localparam logic [1:0] CauseTimeout  = 2'd3;

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             halted_q, halted_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic load_use;
    logic undef;

    // r0 is an ordinary register here, so a match on index 0 still interlocks.
    always_comb begin
        load_use = ex_memRead && id_valid &&
                   ((ex_mem_rd == id_alu_rm) ||
                    (id_alu_useRn && (ex_mem_rd == id_alu_rn)) ||
                    (ex_mem_rd == id_mem_rn) ||
                    (id_mem_isStore && (ex_mem_rd == id_mem_rd)));
        undef = ex_alu_undefinedInstruction || ex_mem_undefinedInstruction;
    end

    always_comb begin
        state_d              = state_q;
        wait_d               = wait_q;
        halted_d             = halted_q;
        cause_d              = cause_q;
        pc_write             = 1'b0;
        p1_pipeline_regWrite = 1'b0;
        p2_pipeline_regWrite = 1'b0;
        p3_pipeline_regWrite = 1'b0;
        p1_flush             = 1'b0;
        p2_flush             = 1'b0;

        unique case (state_q)
            StRun: begin
                if (undef) begin
                    state_d  = StHalt;
                    halted_d = 1'b1;
                    cause_d  = ex_alu_undefinedInstruction ? CauseAluUndef : CauseMemUndef;
                end else if (dmem_req && !dmem_ready) begin
                    state_d = StMemWait;
                    wait_d  = WaitW'(1);
                end else if (ex_branchTaken || ex_isJump) begin
                    // Redirect wins over any load-use match: the dependent bundle is squashed.
                    pc_write             = 1'b1;
                    p1_pipeline_regWrite = 1'b1;
                    p2_pipeline_regWrite = 1'b1;
                    p3_pipeline_regWrite = 1'b1;
                    p1_flush             = 1'b1;
                    p2_flush             = 1'b1;
                end else if (load_use) begin
                    p2_pipeline_regWrite = 1'b1;
                    p3_pipeline_regWrite = 1'b1;
                    p2_flush             = 1'b1;
                end else begin
                    pc_write             = 1'b1;
                    p1_pipeline_regWrite = 1'b1;
                    p2_pipeline_regWrite = 1'b1;
                    p3_pipeline_regWrite = 1'b1;
                end
            end
            StMemWait: begin
                if (dmem_ready) begin
                    state_d = StRun;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                    if (32'(wait_q) + 32'd1 >= MEM_TIMEOUT) begin
                        state_d  = StHalt;
                        halted_d = 1'b1;
                        cause_d  = CauseTimeout;
                    end
                end
            end
            StHalt: begin
            end
            default: state_d = StRun;
        endcase

        if (reset) begin
            pc_write             = 1'b0;
            p1_pipeline_regWrite = 1'b0;
            p2_pipeline_regWrite = 1'b0;
            p3_pipeline_regWrite = 1'b0;
            p1_flush             = 1'b0;
            p2_flush             = 1'b0;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!pc_write && !halted_q && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StRun;
            wait_q   <= '0;
            halted_q <= 1'b0;
            cause_q  <= CauseNone;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            halted_q <= halted_d;
            cause_q  <= cause_d;
            stall_q  <= stall_d;
        end
    end

    assign halted      = halted_q;
    assign halt_cause  = cause_q;
    assign stall_count = stall_q;

endmodule
